// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 FSM encodings, Rcon table and GF(2^8) helpers
package aes_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_KEYEXP = 3'd1;
  localparam logic [2:0] ST_INIT   = 3'd2;
  localparam logic [2:0] ST_ROUND  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte 4c+r is row r of column c; byte 0 sits in bits [127:120]
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * src + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m0, m1, m2, m3;
    o  = '0;
    m0 = inv ? 8'h0e : 8'h02;
    m1 = inv ? 8'h0b : 8'h03;
    m2 = inv ? 8'h0d : 8'h01;
    m3 = inv ? 8'h09 : 8'h01;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127 - 8 * (4 * c + r) -: 8];
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = gmul(a[r], m0) ^ gmul(a[(r + 1) % 4], m1)
                                      ^ gmul(a[(r + 2) % 4], m2) ^ gmul(a[(r + 3) % 4], m3);
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - forward or inverse AES S-box built from GF inverse and affine map
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  input  logic       inv_i,
  output logic [7:0] out_o
);

  logic [7:0] pre;
  logic [7:0] inv_v;

  always_comb begin
    pre   = inv_i ? (rotl8(in_i, 1) ^ rotl8(in_i, 3) ^ rotl8(in_i, 6) ^ 8'h05) : in_i;
    inv_v = gf_inv(pre);
    out_o = inv_i ? inv_v
                  : (inv_v ^ rotl8(inv_v, 1) ^ rotl8(inv_v, 2) ^ rotl8(inv_v, 3)
                     ^ rotl8(inv_v, 4) ^ 8'h63);
  end

endmodule

// File: rtl/aes_top.sv
// rtl/aes_top.sv - iterative AES-128 encrypt/decrypt, one key word set or round per cycle
module aes_top
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         resetAES,
  input  logic [127:0] key,
  input  logic [127:0] data_in,
  input  logic         enable,
  input  logic         ED,
  output logic         completedFlag,
  output logic [127:0] data_out
);

  logic [2:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         ed_q, ed_d;
  logic         flag_q, flag_d;
  logic [127:0] st_q, st_d;
  logic [127:0] dout_q, dout_d;
  logic [127:0] rk_q [11];
  logic         rk_we;
  logic [3:0]   rk_widx;
  logic [127:0] rk_wdata;

  logic [127:0] sb_in, sb_out, round_key, round_out, tmp;
  logic [127:0] prev_rk, rk_next;
  logic [31:0]  rot_w, sub_w, temp_w, w0, w1, w2, w3;
  logic [3:0]   rk_ridx;

  // Decrypt applies InvShiftRows before the shared S-box bank; encrypt applies ShiftRows after
  assign sb_in = ed_q ? st_q : shift_rows(st_q, 1'b1);

  genvar g;
  for (g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (.in_i(sb_in[8*g +: 8]), .inv_i(~ed_q), .out_o(sb_out[8*g +: 8]));
  end

  assign rk_ridx   = ed_q ? cnt_q : 4'd10 - cnt_q;
  assign round_key = rk_q[rk_ridx];

  always_comb begin
    tmp = '0;
    if (ed_q) begin
      tmp = shift_rows(sb_out, 1'b0);
      if (cnt_q != 4'd10) tmp = mix_columns(tmp, 1'b0);
      round_out = tmp ^ round_key;
    end else begin
      tmp = sb_out ^ round_key;
      if (cnt_q != 4'd10) tmp = mix_columns(tmp, 1'b1);
      round_out = tmp;
    end
  end

  assign prev_rk = rk_q[cnt_q];
  assign rot_w   = {prev_rk[23:0], prev_rk[31:24]};

  for (g = 0; g < 4; g++) begin : g_ksbox
    aes_sbox u_ksbox (.in_i(rot_w[8*g +: 8]), .inv_i(1'b0), .out_o(sub_w[8*g +: 8]));
  end

  assign temp_w  = sub_w ^ {rcon(cnt_q), 24'h0};
  assign w0      = prev_rk[127:96] ^ temp_w;
  assign w1      = prev_rk[95:64] ^ w0;
  assign w2      = prev_rk[63:32] ^ w1;
  assign w3      = prev_rk[31:0] ^ w2;
  assign rk_next = {w0, w1, w2, w3};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ed_d     = ed_q;
    flag_d   = flag_q;
    st_d     = st_q;
    dout_d   = dout_q;
    rk_we    = 1'b0;
    rk_widx  = cnt_q + 4'd1;
    rk_wdata = rk_next;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          rk_we    = 1'b1;
          rk_widx  = 4'd0;
          rk_wdata = key;
          st_d     = data_in;
          ed_d     = ED;
          cnt_d    = 4'd0;
          state_d  = ST_KEYEXP;
        end
      end
      ST_KEYEXP: begin
        rk_we = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = ST_INIT;
      end
      ST_INIT: begin
        st_d    = st_q ^ (ed_q ? rk_q[0] : rk_q[10]);
        cnt_d   = 4'd1;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        st_d = round_out;
        if (cnt_q == 4'd10) begin
          dout_d  = round_out;
          flag_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          flag_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetAES) begin
    if (!resetAES) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ed_q    <= 1'b0;
      flag_q  <= 1'b0;
      st_q    <= '0;
      dout_q  <= '0;
      for (int k = 0; k < 11; k++) rk_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ed_q    <= ed_d;
      flag_q  <= flag_d;
      st_q    <= st_d;
      dout_q  <= dout_d;
      if (rk_we) rk_q[rk_widx] <= rk_wdata;
    end
  end

  assign completedFlag = flag_q;
  assign data_out      = dout_q;

endmodule

// File: tb/tb_aes_top.sv
// tb/tb_aes_top.sv - directed known-answer bench for aes_top
module tb_aes_top;

  logic         clock;
  logic         resetAES;
  logic [127:0] key;
  logic [127:0] data_in;
  logic         enable;
  logic         ED;
  logic         completedFlag;
  logic [127:0] data_out;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_top dut (
    .clock(clock),
    .resetAES(resetAES),
    .key(key),
    .data_in(data_in),
    .enable(enable),
    .ED(ED),
    .completedFlag(completedFlag),
    .data_out(data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [127:0] k, input logic [127:0] d, input logic e);
    @(negedge clock);
    key     = k;
    data_in = d;
    ED      = e;
    enable  = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Edges from now until completedFlag first reads high; 0 if the budget runs out
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (completedFlag) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [127:0] k, input logic [127:0] d,
                        input logic e, input logic [127:0] exp);
    int lat;
    start_op(k, d, e);
    enable = 1'b0;
    wait_done(lat);
    check({tag, "_latency"}, 128'(lat), 128'd21);
    check({tag, "_result"}, data_out, exp);
    @(posedge clock);
    #1;
    check({tag, "_flag_clear"}, {127'd0, completedFlag}, 128'd0);
    check({tag, "_hold"}, data_out, exp);
  endtask

  initial begin
    int lat;
    resetAES = 1'b0;
    enable   = 1'b0;
    key      = '0;
    data_in  = '0;
    ED       = 1'b0;
    #3;
    check("reset_flag", {127'd0, completedFlag}, 128'd0);
    check("reset_dout", data_out, 128'd0);
    repeat (2) @(negedge clock);
    resetAES = 1'b1;

    run_op("enc1", K1, P1, 1'b1, C1);
    run_op("dec1", K1, C1, 1'b0, P1);
    run_op("enc2", K2, P2, 1'b1, C2);
    run_op("dec2", K2, C2, 1'b0, P2);

    // Abort mid-operation: outputs clear at once, no partial result afterwards
    start_op(K1, P1, 1'b1);
    enable = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    resetAES = 1'b0;
    #1;
    check("abort_flag", {127'd0, completedFlag}, 128'd0);
    check("abort_dout", data_out, 128'd0);
    repeat (2) @(posedge clock);
    #1;
    check("abort_dout_stays", data_out, 128'd0);
    @(negedge clock);
    resetAES = 1'b1;
    run_op("post_reset", K2, P2, 1'b1, C2);

    // enable held high through DONE must not retrigger
    start_op(K1, P1, 1'b1);
    wait_done(lat);
    check("hold_latency", 128'(lat), 128'd21);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("hold_flag_%0d", i), {127'd0, completedFlag}, 128'd1);
      check($sformatf("hold_dout_%0d", i), data_out, C1);
    end
    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    #1;
    check("hold_drop_flag", {127'd0, completedFlag}, 128'd0);
    check("hold_drop_dout", data_out, C1);

    // Inputs scrambled during ROUND must not affect the captured operation
    start_op(K2, C2, 1'b0);
    enable = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    key     = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    data_in = 128'h0;
    ED      = 1'b1;
    enable  = 1'b1;
    wait_done(lat);
    check("scramble_latency", 128'(lat), 128'd7);
    check("scramble_result", data_out, P2);
    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    #1;
    check("scramble_flag_clear", {127'd0, completedFlag}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_top.md
AES_TOP -- requirements
Module: aes_top

Interface
REQ-001 No parameters; fixed AES-128, 128-bit key/block, byte 0 = bits [127:120], FIPS-197 byte order.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 resetAES  input  1  asynchronous active-low reset.
REQ-005 key  input  128  cipher key, sampled only at the capture edge.
REQ-006 data_in  input  128  plaintext (encrypt) or ciphertext (decrypt), sampled at the capture edge.
REQ-007 enable  input  1  start request, level-sensitive.
REQ-008 ED  input  1  mode: 1 = encrypt, 0 = decrypt, sampled at the capture edge.
REQ-009 completedFlag  output  1  high while a valid result is held on data_out.
REQ-010 data_out  output  128  result block, registered.

Function
REQ-011 States: IDLE, KEYEXP, INIT, ROUND, DONE.
REQ-012 IDLE with enable=1 at edge N is the capture edge: latch key into rk[0], latch data_in and ED, clear the counter, go to KEYEXP.
REQ-013 KEYEXP, edges N+1..N+10: compute rk[1..10] one per cycle via standard AES-128 expansion (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36); go to INIT.
REQ-014 INIT, edge N+11: state = block XOR rk[0] if encrypting, XOR rk[10] if decrypting; go to ROUND.
REQ-015 Encrypt rounds r=1..10: SubBytes, ShiftRows, MixColumns (omitted at r=10), AddRoundKey rk[r].
REQ-016 Decrypt rounds r=1..10: InvShiftRows, InvSubBytes, AddRoundKey rk[10-r], InvMixColumns (omitted at r=10).
REQ-017 ROUND, edges N+12..N+21: one round per edge; at edge N+21 write the final state to data_out, set completedFlag=1, go to DONE.
REQ-018 Fixed latency: completedFlag first reads 1 after edge N+21, 21 cycles after capture, for either mode.
REQ-019 DONE holds completedFlag=1 and data_out stable while enable=1; enable=0 in DONE clears completedFlag at the next edge and returns to IDLE.
REQ-020 data_out keeps its last result after leaving DONE, until the next result or reset.
REQ-021 enable changes and key/data_in/ED changes during KEYEXP/INIT/ROUND are ignored; an operation always completes.
REQ-022 Leaving DONE and starting again requires enable low for at least one edge; enable held high does not retrigger.
REQ-023 GF(2^8) arithmetic uses polynomial x^8+x^4+x^3+x+1 (0x11b).

Reset
REQ-024 resetAES=0 forces state IDLE, completedFlag=0, data_out=0, internal state/round keys/counter=0, asynchronously.
REQ-025 Reset mid-operation aborts it; no partial result appears on data_out.
REQ-026 Release is synchronous to clock; the first capture can occur at the first edge after release.

Structure
REQ-027 Shared package aes_pkg holds the FSM state enum, the Rcon table, and xtime/gmul functions.
REQ-028 One sub-module, aes_sbox: 8-bit in, mode bit, 8-bit out; forward or inverse S-box.
REQ-029 aes_sbox is instantiated 16x for the datapath and 4x for key expansion.
REQ-030 aes_sbox may be a table or the algebraic GF inverse plus affine map.

Verification
REQ-031 Encrypt, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a with completedFlag high exactly 21 cycles after capture.
REQ-032 Decrypt, same key, data 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff.
REQ-033 Encrypt, key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; decrypt of that output returns the plaintext.
REQ-034 Assert resetAES=0 at cycle 10 of an operation -> completedFlag=0 and data_out=0 immediately; a fresh operation afterwards gives the correct result.
REQ-035 Hold enable=1 through DONE for 5 cycles -> completedFlag stays 1 with no restart; drop enable -> completedFlag=0 next edge and data_out holds.
REQ-036 Change key/data_in/ED during ROUND -> the result matches the captured inputs.
